dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the byte-addressed, big-endian 256-byte data memory (DMEM). It shares DMEM's single port between requester A (CPU load/store stage) and requester B (DMA/debug loader). Arbitration is round-robin. It drives DMEM's write strobe so that the memory's negedge write lands mid-cycle. It captures read data into a per-port register and range-checks every word access before it reaches the memory.

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single DMEM port between a CPU
// requester (A) and a DMA/debug requester (B). Each granted access runs
// IDLE -> ACCESS -> RESP, so at most one access completes every three cycles.
//
// Handshake: a requester raises req with we/address/wdata valid and holds all
// of them until it samples ack=1. The ack is a one-cycle pulse and err is
// valid alongside it. A req that is still high two cycles after the ack is
// treated as a new transaction.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        A_req,
    input  logic        A_we,
    input  logic [31:0] A_address,
    input  logic [31:0] A_wdata,
    output logic        A_ack,
    output logic        A_err,
    output logic [31:0] A_rdata,
    input  logic        B_req,
    input  logic        B_we,
    input  logic [31:0] B_address,
    input  logic [31:0] B_wdata,
    output logic        B_ack,
    output logic        B_err,
    output logic [31:0] B_rdata,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out,
    output logic [1:0]  state_o
);

    // Highest byte address at which a full 4-byte word still fits.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_b_q, last_b_d;   // 1 = B was granted most recently
    logic        port_q, port_d;       // 1 = current access belongs to B
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic        a_err_q, a_err_d, b_err_q, b_err_d;
    logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic        grant_b;

    // Next-state, arbitration, and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_err_d    = a_err_q;
        b_err_d    = b_err_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        mem_addr_d = PARK_ADDR;
        mem_din_d  = 32'h0;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        grant_b    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (A_req || B_req) begin
                    // On a tie, serve whichever port was not served last.
                    grant_b  = B_req && (!A_req || !last_b_q);
                    port_d   = grant_b;
                    last_b_d = grant_b;
                    we_d     = grant_b ? B_we      : A_we;
                    addr_d   = grant_b ? B_address : A_address;
                    wdata_d  = grant_b ? B_wdata   : A_wdata;
                    err_d    = (addr_d > LAST_WORD);
                    state_d  = S_ACCESS;
                    // Out-of-range accesses leave the memory port parked.
                    if (!err_d) begin
                        mem_addr_d = addr_d;
                        mem_din_d  = wdata_d;
                        mem_we_d   = we_d;
                        mem_re_d   = !we_d;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (port_q) begin
                    b_ack_d = 1'b1;
                    b_err_d = err_q;
                    if (!we_q) b_rdata_d = err_q ? 32'h0 : DMEM_data_out;
                end else begin
                    a_ack_d = 1'b1;
                    a_err_d = err_q;
                    if (!we_q) a_rdata_d = err_q ? 32'h0 : DMEM_data_out;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the memory port at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_b_q   <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= 32'h0;
            b_rdata_q  <= 32'h0;
            mem_addr_q <= PARK_ADDR;
            mem_din_q  <= 32'h0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
        end
    end

    assign A_ack          = a_ack_q;
    assign A_err          = a_err_q;
    assign A_rdata        = a_rdata_q;
    assign B_ack          = b_ack_q;
    assign B_err          = b_err_q;
    assign B_rdata        = b_rdata_q;
    assign DMEM_address   = mem_addr_q;
    assign DMEM_data_in   = mem_din_q;
    assign DMEM_mem_write = mem_we_q;
    assign DMEM_mem_read  = mem_re_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian 256-byte memory model
// that commits writes on the falling clock edge.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        A_req, A_we, B_req, B_we;
    logic [31:0] A_address, A_wdata, B_address, B_wdata;
    logic        A_ack, A_err, B_ack, B_err;
    logic [31:0] A_rdata, B_rdata;
    logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
    logic        DMEM_mem_write, DMEM_mem_read;
    logic [1:0]  state_o;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .A_req(A_req), .A_we(A_we), .A_address(A_address), .A_wdata(A_wdata),
        .A_ack(A_ack), .A_err(A_err), .A_rdata(A_rdata),
        .B_req(B_req), .B_we(B_we), .B_address(B_address), .B_wdata(B_wdata),
        .B_ack(B_ack), .B_err(B_err), .B_rdata(B_rdata),
        .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
        .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
        .DMEM_data_out(DMEM_data_out), .state_o(state_o)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:255];
    bit mem_init = 1'b0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[252] = 8'hA5; mem[253] = 8'h5A; mem[254] = 8'hC3; mem[255] = 8'h3C;
            mem_init = 1'b1;
        end else if (DMEM_mem_write && DMEM_address <= 32'd252) begin
            mem[DMEM_address[7:0]]        = DMEM_data_in[31:24];
            mem[DMEM_address[7:0] + 8'd1] = DMEM_data_in[23:16];
            mem[DMEM_address[7:0] + 8'd2] = DMEM_data_in[15:8];
            mem[DMEM_address[7:0] + 8'd3] = DMEM_data_in[7:0];
        end
    end

    assign DMEM_data_out = (DMEM_address <= 32'd252) ?
        {mem[DMEM_address[7:0]], mem[DMEM_address[7:0] + 8'd1],
         mem[DMEM_address[7:0] + 8'd2], mem[DMEM_address[7:0] + 8'd3]} : 32'h0;

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    logic [31:0] t_lat, t_err, t_rdata, addr_pre, addr_acc, addr_resp;
    logic [31:0] wr_acc, rd_acc, ack_after;

    task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        if (port) begin
            B_req = 1'b1; B_we = we; B_address = addr; B_wdata = wdata;
        end else begin
            A_req = 1'b1; A_we = we; A_address = addr; A_wdata = wdata;
        end
        addr_pre = DMEM_address;
        seen = 1'b0;
        cyc = 0;
        t_lat = 0; t_err = 0; t_rdata = 0; addr_acc = 0; addr_resp = 0;
        wr_acc = 0; rd_acc = 0;
        while (!seen && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                addr_acc = DMEM_address;
                wr_acc   = {31'h0, DMEM_mem_write};
                rd_acc   = {31'h0, DMEM_mem_read};
            end
            if ((port ? B_ack : A_ack) === 1'b1) begin
                seen      = 1'b1;
                t_lat     = cyc;
                t_err     = {31'h0, port ? B_err : A_err};
                t_rdata   = port ? B_rdata : A_rdata;
                addr_resp = DMEM_address;
                A_req = 1'b0;
                B_req = 1'b0;
            end
        end
        check("ack_seen", {31'h0, seen}, 32'h1);
        A_req = 1'b0;
        B_req = 1'b0;
        @(posedge clk); #1;
        ack_after = {31'h0, port ? B_ack : A_ack};
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] obs;

    initial begin
        rst_n = 1'b0;
        A_req = 0; A_we = 0; A_address = 0; A_wdata = 0;
        B_req = 0; B_we = 0; B_address = 0; B_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {30'h0, state_o}, 32'h0);
        check("rst_a_ack", {31'h0, A_ack}, 32'h0);
        check("rst_b_ack", {31'h0, B_ack}, 32'h0);
        check("rst_a_err", {31'h0, A_err}, 32'h0);
        check("rst_b_err", {31'h0, B_err}, 32'h0);
        check("rst_a_rdata", A_rdata, 32'h0);
        check("rst_b_rdata", B_rdata, 32'h0);
        check("rst_dmem_addr", DMEM_address, PARK);
        check("rst_dmem_we", {31'h0, DMEM_mem_write}, 32'h0);
        check("rst_dmem_re", {31'h0, DMEM_mem_read}, 32'h0);
        check("rst_dmem_din", DMEM_data_in, 32'h0);
        rst_n = 1'b1;

        // A writes DEADBEEF to 8
        run_txn(1'b0, 1'b1, 32'd8, 32'hDEADBEEF);
        check("wr8_latency", t_lat, 32'd2);
        check("wr8_err", t_err, 32'h0);
        check("wr8_ack_pulse", ack_after, 32'h0);
        check("wr8_acc_addr", addr_acc, 32'd8);
        check("wr8_acc_we", wr_acc, 32'h1);
        check("wr8_acc_re", rd_acc, 32'h0);
        check("wr8_mem", mem_word(8), 32'hDEADBEEF);
        check("wr8_a_rdata_kept", A_rdata, 32'h0);

        // A reads 8 back; address parks around the access
        run_txn(1'b0, 1'b0, 32'd8, 32'h0);
        check("rd8_rdata", t_rdata, 32'hDEADBEEF);
        check("rd8_err", t_err, 32'h0);
        check("rd8_addr_pre", addr_pre, PARK);
        check("rd8_addr_acc", addr_acc, 32'd8);
        check("rd8_addr_resp", addr_resp, PARK);
        check("rd8_acc_re", rd_acc, 32'h1);
        check("rd8_acc_we", wr_acc, 32'h0);
        check("rd8_b_rdata_kept", B_rdata, 32'h0);

        // Simultaneous requests straight out of reset: A, B, A
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst2_a_rdata", A_rdata, 32'h0);
        exp_q.push_back(32'h0000_0002);  // A acked at cycle 2
        exp_q.push_back(32'h0001_0005);  // B acked at cycle 5
        exp_q.push_back(32'h0000_0008);  // A acked at cycle 8
        A_req = 1'b1; A_we = 1'b1; A_address = 32'd16; A_wdata = 32'h1111_1111;
        B_req = 1'b1; B_we = 1'b1; B_address = 32'd20; B_wdata = 32'h2222_2222;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (A_ack === 1'b1) begin
                obs = {16'h0000, 16'(c)};
                if (exp_q.size() > 0) check("rr_grant", obs, exp_q.pop_front());
                else check("rr_extra_grant", obs, PARK);
            end
            if (B_ack === 1'b1) begin
                obs = {16'h0001, 16'(c)};
                if (exp_q.size() > 0) check("rr_grant", obs, exp_q.pop_front());
                else check("rr_extra_grant", obs, PARK);
            end
        end
        A_req = 1'b0;
        B_req = 1'b0;
        check("rr_missing_grants", exp_q.size(), 32'd0);
        check("rr_mem16", mem_word(16), 32'h1111_1111);
        check("rr_mem20", mem_word(20), 32'h2222_2222);
        repeat (3) @(posedge clk);

        // B range checks
        run_txn(1'b1, 1'b0, 32'd8, 32'h0);
        check("b_rd8_rdata", t_rdata, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 32'd253, 32'h0);
        check("b_rd253_err", t_err, 32'h1);
        check("b_rd253_rdata", t_rdata, 32'h0);
        check("b_rd253_re", rd_acc, 32'h0);
        check("b_rd253_we", wr_acc, 32'h0);
        check("b_rd253_addr", addr_acc, PARK);
        run_txn(1'b1, 1'b1, 32'd253, 32'hFFFF_FFFF);
        check("b_wr253_err", t_err, 32'h1);
        check("b_wr253_we", wr_acc, 32'h0);
        check("b_wr253_mem", mem_word(252), 32'hA55A_C33C);
        check("b_wr253_rdata_kept", B_rdata, 32'h0);
        run_txn(1'b1, 1'b0, 32'd252, 32'h0);
        check("b_rd252_err", t_err, 32'h0);
        check("b_rd252_rdata", t_rdata, 32'hA55A_C33C);

        // Read, foreign write, read at address 0
        run_txn(1'b0, 1'b0, 32'd0, 32'h0);
        check("a_rd0_first", t_rdata, 32'h0);
        run_txn(1'b1, 1'b1, 32'd0, 32'h1234_5678);
        check("b_wr0_err", t_err, 32'h0);
        check("b_wr0_rdata_kept", B_rdata, 32'hA55A_C33C);
        check("b_wr0_a_rdata_kept", A_rdata, 32'h0);
        run_txn(1'b0, 1'b0, 32'd0, 32'h0);
        check("a_rd0_second", t_rdata, 32'h1234_5678);

        // Reset during ACCESS of a write, before the falling edge
        @(posedge clk); #1;
        A_req = 1'b1; A_we = 1'b1; A_address = 32'd40; A_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("mid_state_access", {30'h0, state_o}, 32'h1);
        check("mid_we_before", {31'h0, DMEM_mem_write}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_we_after_rst", {31'h0, DMEM_mem_write}, 32'h0);
        check("mid_addr_after_rst", DMEM_address, PARK);
        check("mid_state_after_rst", {30'h0, state_o}, 32'h0);
        check("mid_b_rdata_rst", B_rdata, 32'h0);
        A_req = 1'b0;
        @(negedge clk); #1;
        check("mid_mem40_untouched", mem_word(40), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 32'd40, 32'h0);
        check("post_rst_rd40", t_rdata, 32'h0);
        check("post_rst_latency", t_lat, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
